// File: rtl/packet_queue_wr_arb_pkg.sv
// Shared types and helpers for the packet queue write arbiter.
package packet_queue_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // Widest request vector the round-robin helper handles.
  localparam int unsigned RR_MAX_N = 32;
  localparam int unsigned RR_IDX_W = $clog2(RR_MAX_N);

  // First set request at or after ptr, wrapping. Requests above the real
  // source count are zero, so wrapping at RR_MAX_N equals wrapping at N.
  function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [RR_MAX_N-1:0] req,
                                                  input logic [RR_IDX_W-1:0] ptr);
    logic [RR_IDX_W-1:0] idx;
    logic                found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < RR_MAX_N; k++) begin
      idx = ptr + RR_IDX_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/packet_queue_wr_arb_rr.sv
// Combinational round-robin pick from a request vector and a pointer.
module rr_arbiter_ptr
  import packet_queue_wr_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  logic [RR_IDX_W-1:0] pick_w;

  // Winner index is always below N, so the narrowing keeps it intact.
  always_comb begin
    pick_w = rr_pick(RR_MAX_N'(req), RR_IDX_W'(ptr));
    pick   = IDX_W'(pick_w);
    any    = |req;
  end

endmodule

// File: rtl/packet_queue_wr_arb.sv
// Packet-granular round-robin write arbiter in front of one packet_queue.
// Optional statistics counters are built when PKT_Q_WR_ARB_STATS_EN is defined.
module packet_queue_wr_arb
  import packet_queue_wr_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC_P     = 4,
  parameter int unsigned DATA_W_P      = 256,
  parameter int unsigned LOG2_ELS_P    = 6,
  parameter int unsigned MAX_PKT_ELS_P = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC_P-1:0]            src_val,
  input  logic [NUM_SRC_P*DATA_W_P-1:0]   src_data,
  input  logic [NUM_SRC_P-1:0]            src_last,
  input  logic [NUM_SRC_P-1:0]            src_err,
  output logic [NUM_SRC_P-1:0]            src_rdy,
  output logic                            q_wr_req,
  output logic [DATA_W_P-1:0]             q_wr_data,
  input  logic                            q_full,
  output logic                            q_cmt_packet,
  output logic                            q_dump_packet,
  output logic                            pkt_cmt_val,
  output logic [$clog2(NUM_SRC_P)-1:0]    pkt_cmt_src,
  output logic [LOG2_ELS_P:0]             pkt_cmt_len
`ifdef PKT_Q_WR_ARB_STATS_EN
  ,
  input  logic                            stat_clr,
  output logic [31:0]                     stat_cmt_cnt,
  output logic [31:0]                     stat_drop_err_cnt,
  output logic [31:0]                     stat_drop_ovf_cnt
`endif
);

  localparam int unsigned SRC_IDX_W = $clog2(NUM_SRC_P);
  localparam int unsigned CNT_W     = LOG2_ELS_P + 1;

  arb_state_e           state;
  logic [SRC_IDX_W-1:0] g;
  logic [SRC_IDX_W-1:0] rr;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;

  logic [SRC_IDX_W-1:0] pick;
  logic                 any_req;
  logic [SRC_IDX_W-1:0] g_nxt;
  logic [CNT_W-1:0]     cnt_inc;
  logic [DATA_W_P-1:0]  src_beat [NUM_SRC_P];

  rr_arbiter_ptr #(.N(NUM_SRC_P)) u_rr (
    .req  (src_val),
    .ptr  (rr),
    .pick (pick),
    .any  (any_req)
  );

  // Unpack per-source beats and derive pointer/count increments.
  always_comb begin
    for (int i = 0; i < NUM_SRC_P; i++) begin
      src_beat[i] = src_data[i*DATA_W_P +: DATA_W_P];
    end
    g_nxt   = (g == SRC_IDX_W'(NUM_SRC_P - 1)) ? '0 : g + SRC_IDX_W'(1);
    cnt_inc = cnt + CNT_W'(1);
  end

  // Handshake and queue controls follow the granted source in the same cycle.
  always_comb begin
    src_rdy       = '0;
    q_wr_req      = 1'b0;
    q_wr_data     = '0;
    q_cmt_packet  = 1'b0;
    q_dump_packet = 1'b0;
    pkt_cmt_val   = 1'b0;
    pkt_cmt_src   = '0;
    pkt_cmt_len   = '0;
    case (state)
      XFER: begin
        src_rdy[g] = ~q_full;
        if (src_val[g] && !q_full) begin
          if (src_err[g] || ovf) begin
            q_dump_packet = 1'b1;
          end else begin
            q_wr_req  = 1'b1;
            q_wr_data = src_beat[g];
            if (src_last[g]) begin
              q_cmt_packet = 1'b1;
              pkt_cmt_val  = 1'b1;
              pkt_cmt_src  = g;
              pkt_cmt_len  = cnt_inc;
            end
          end
        end
      end
      DRAIN: src_rdy[g] = 1'b1;
      default: ;
    endcase
  end

  // Arbitration, beat counting, overflow tracking and packet sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      g     <= '0;
      rr    <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            g     <= pick;
            cnt   <= '0;
            ovf   <= 1'b0;
            state <= XFER;
          end
        end
        XFER: begin
          if (q_dump_packet) begin
            cnt   <= '0;
            ovf   <= 1'b0;
            rr    <= g_nxt;
            state <= src_last[g] ? IDLE : DRAIN;
          end else if (q_cmt_packet) begin
            cnt   <= '0;
            rr    <= g_nxt;
            state <= IDLE;
          end else if (q_wr_req) begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_W'(MAX_PKT_ELS_P)) ovf <= 1'b1;
          end
        end
        DRAIN: begin
          if (src_val[g] && src_last[g]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PKT_Q_WR_ARB_STATS_EN
  logic inc_cmt;
  logic inc_err;
  logic inc_ovf;

  // Saturating increment; an increment in a clear cycle yields 1.
  function automatic logic [31:0] stat_next(input logic [31:0] v, input logic inc,
                                            input logic clr);
    if (inc)      stat_next = clr ? 32'd1 : ((v == 32'hFFFF_FFFF) ? v : v + 32'd1);
    else if (clr) stat_next = '0;
    else          stat_next = v;
  endfunction

  // Classify each packet outcome for the counters.
  always_comb begin
    inc_cmt = pkt_cmt_val;
    inc_err = q_dump_packet & src_err[g];
    inc_ovf = q_dump_packet & ~src_err[g];
  end

  // Commit and drop statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cmt_cnt      <= '0;
      stat_drop_err_cnt <= '0;
      stat_drop_ovf_cnt <= '0;
    end else begin
      stat_cmt_cnt      <= stat_next(stat_cmt_cnt, inc_cmt, stat_clr);
      stat_drop_err_cnt <= stat_next(stat_drop_err_cnt, inc_err, stat_clr);
      stat_drop_ovf_cnt <= stat_next(stat_drop_ovf_cnt, inc_ovf, stat_clr);
    end
  end
`endif

endmodule
